// File: rtl/ccr_register_file_if.sv
// Bus interface for ccr_register_file: active-low strobes, word address,
// write data and registered read data.
interface ccr_register_file_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 16
);
  logic                  memory_enable_n;
  logic                  memory_write_n;
  logic                  memory_read_n;
  logic [ADDR_WIDTH-1:0] memory_address;
  logic [DATA_WIDTH-1:0] memory_data_in;
  logic [DATA_WIDTH-1:0] memory_data_out;

  modport master (
    output memory_enable_n, memory_write_n, memory_read_n,
    output memory_address, memory_data_in,
    input  memory_data_out
  );

  modport slave (
    input  memory_enable_n, memory_write_n, memory_read_n,
    input  memory_address, memory_data_in,
    output memory_data_out
  );
endinterface

// File: rtl/ccr_register_file.sv
// Compare-channel register file: cell_state, CTRL and NUM_CHANNELS 2-word CCRs.
// Define CCR_SHADOW_EN for staging/active double buffering committed on period_sync.
module ccr_register_file #(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 8
) (
  input  logic                                 clock,
  input  logic                                 reset_sn,
  ccr_register_file_if.slave                   bus,
  input  logic                                 period_sync,
  output logic [DATA_WIDTH-1:0]                cell_state,
  output logic [NUM_CHANNELS*2*DATA_WIDTH-1:0] ccr_flat,
  output logic                                 commit_pending
);
  localparam int FLAT_W    = NUM_CHANNELS * 2 * DATA_WIDTH;
  localparam int MAP_WORDS = 2 + 2 * NUM_CHANNELS;
  localparam int XW        = (DATA_WIDTH > 16) ? DATA_WIDTH : 16;

  logic                  w_wr_en, w_rd_en;
  logic                  w_mapped, w_ccr_hit;
  logic                  w_ctrl_wr, w_ccr_wr;
  logic                  w_commit_bit;
  int                    w_addr_int;
  int                    w_bit_off;
  logic [DATA_WIDTH-1:0] w_ctrl_rd;
  logic [DATA_WIDTH-1:0] w_rd_word;
  logic [FLAT_W-1:0]     w_ccr_view;

  logic [DATA_WIDTH-1:0] r_cell_state;
  logic                  r_immediate;
  logic [DATA_WIDTH-1:0] r_rdata;

  assign w_wr_en    = !bus.memory_enable_n && !bus.memory_write_n;
  assign w_rd_en    = !bus.memory_enable_n && !bus.memory_read_n;
  assign w_addr_int = int'(bus.memory_address);
  assign w_mapped   = w_addr_int < MAP_WORDS;
  assign w_ccr_hit  = w_mapped && (w_addr_int >= 2);
  assign w_ctrl_wr  = w_wr_en && (w_addr_int == 1);
  assign w_ccr_wr   = w_wr_en && w_ccr_hit;
  // Low half of channel k sits at word 2+2k, so word offset times width is the flat bit offset.
  assign w_bit_off  = (w_addr_int - 2) * DATA_WIDTH;
  // Bit 15 of the write data, reading as 0 when the bus is narrower than 16 bits.
  assign w_commit_bit = 1'(XW'(bus.memory_data_in) >> 15);
  assign w_ctrl_rd    = DATA_WIDTH'({commit_pending, 14'b0, r_immediate});

  always_comb begin
    // NOTE: default first so every path assigns w_rd_word and no latch is inferred.
    w_rd_word = '0;
    if (w_mapped) begin
      if (w_addr_int == 0)      w_rd_word = r_cell_state;
      else if (w_addr_int == 1) w_rd_word = w_ctrl_rd;
      else                      w_rd_word = w_ccr_view[w_bit_off +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clock or negedge reset_sn) begin
    if (!reset_sn) begin
      r_cell_state <= '0;
      r_immediate  <= 1'b0;
      r_rdata      <= '0;
    end else begin
      // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
      r_rdata <= w_rd_en ? w_rd_word : '0;
      if (w_wr_en && (w_addr_int == 0)) r_cell_state <= bus.memory_data_in;
      if (w_ctrl_wr)                    r_immediate  <= bus.memory_data_in[0];
    end
  end

`ifdef CCR_SHADOW_EN
  logic [FLAT_W-1:0] r_staging;
  logic [FLAT_W-1:0] r_active;
  logic              r_commit_pending;
  logic              w_copy;

  assign w_copy = r_commit_pending && (period_sync || r_immediate);

  always_ff @(posedge clock or negedge reset_sn) begin
    if (!reset_sn) begin
      // NOTE: the CCR arrays are plain flops, so they are cleared by the async reset like any scalar.
      r_staging        <= '0;
      r_active         <= '0;
      r_commit_pending <= 1'b0;
    end else begin
      if (w_ccr_wr) r_staging[w_bit_off +: DATA_WIDTH] <= bus.memory_data_in;
      if (w_copy) begin
        r_active         <= r_staging;
        r_commit_pending <= 1'b0;
      end else if (w_ctrl_wr && w_commit_bit) begin
        r_commit_pending <= 1'b1;
      end
    end
  end

  assign w_ccr_view     = r_staging;
  assign ccr_flat       = r_active;
  assign commit_pending = r_commit_pending;
`else
  logic [FLAT_W-1:0] r_active;
  logic              w_unused_shadow;

  assign w_unused_shadow = period_sync ^ w_commit_bit;

  always_ff @(posedge clock or negedge reset_sn) begin
    if (!reset_sn) begin
      r_active <= '0;
    end else if (w_ccr_wr) begin
      r_active[w_bit_off +: DATA_WIDTH] <= bus.memory_data_in;
    end
  end

  assign w_ccr_view     = r_active;
  assign ccr_flat       = r_active;
  assign commit_pending = 1'b0;
`endif

  assign cell_state          = r_cell_state;
  assign bus.memory_data_out = r_rdata;
endmodule

// File: tb/tb_ccr_register_file.sv
// Directed bench for ccr_register_file with a word-level behavioural model
// checked every cycle, plus literal expectations for the key scenarios.
module tb_ccr_register_file;
  localparam int NCH = 4;
  localparam int DW  = 16;
  localparam int AW  = 8;
`ifdef CCR_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                sync = 1'b0;
  logic [DW-1:0]       cell_state;
  logic [NCH*2*DW-1:0] ccr_flat;
  logic                commit_pending;

  ccr_register_file_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ccr_register_file #(.NUM_CHANNELS(NCH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clock          (clk),
    .reset_sn       (rst_n),
    .bus            (bus.slave),
    .period_sync    (sync),
    .cell_state     (cell_state),
    .ccr_flat       (ccr_flat),
    .commit_pending (commit_pending)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model: word-addressed registers and per-channel halves.
  logic [DW-1:0] m_cell, m_rdata;
  logic          m_imm, m_pend;
  logic [DW-1:0] m_stage [NCH][2];
  logic [DW-1:0] m_act   [NCH][2];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_cell = '0; m_rdata = '0; m_imm = 1'b0; m_pend = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      m_stage[k][0] = '0; m_stage[k][1] = '0;
      m_act[k][0]   = '0; m_act[k][1]   = '0;
    end
  endtask

  function automatic logic [127:0] model_flat();
    logic [127:0] f = '0;
    for (int k = 0; k < NCH; k++) f[k*32 +: 32] = {m_act[k][1], m_act[k][0]};
    return f;
  endfunction

  function automatic logic [DW-1:0] model_read(input int a);
    if (a == 0) return m_cell;
    if (a == 1) return {(SHADOW ? m_pend : 1'b0), 14'b0, m_imm};
    if (a >= 2 && a < 2 + 2 * NCH)
      return SHADOW ? m_stage[(a-2)/2][(a-2)%2] : m_act[(a-2)/2][(a-2)%2];
    return '0;
  endfunction

  // Advance the model by one clock edge using the inputs present before it.
  task automatic model_step();
    bit wr, rd, copy;
    int a;
    logic [DW-1:0] d, rnext;
    wr = !bus.memory_enable_n && !bus.memory_write_n;
    rd = !bus.memory_enable_n && !bus.memory_read_n;
    a  = int'(bus.memory_address);
    d  = bus.memory_data_in;
    rnext = rd ? model_read(a) : '0;
    copy  = SHADOW && m_pend && (sync || m_imm);
    if (copy) begin
      for (int k = 0; k < NCH; k++) begin
        m_act[k][0] = m_stage[k][0]; m_act[k][1] = m_stage[k][1];
      end
      m_pend = 1'b0;
    end else if (SHADOW && wr && a == 1 && d[15]) begin
      m_pend = 1'b1;
    end
    if (wr) begin
      if (a == 0) m_cell = d;
      else if (a == 1) m_imm = d[0];
      else if (a < 2 + 2 * NCH) begin
        if (SHADOW) m_stage[(a-2)/2][(a-2)%2] = d;
        else        m_act[(a-2)/2][(a-2)%2]   = d;
      end
    end
    m_rdata = rnext;
  endtask

  task automatic compare_all();
    check("cell_state", 128'(cell_state), 128'(m_cell));
    check("ccr_flat", 128'(ccr_flat), model_flat());
    check("commit_pending", 128'(commit_pending), 128'(m_pend));
    check("memory_data_out", 128'(bus.memory_data_out), 128'(m_rdata));
  endtask

  // One bus cycle: drive at the falling edge, model on the rising edge, compare 1ns later.
  task automatic cycle(input bit en, input bit wr, input bit rd, input int a,
                       input logic [DW-1:0] d, input bit s);
    bus.memory_enable_n = ~en;
    bus.memory_write_n  = ~wr;
    bus.memory_read_n   = ~rd;
    bus.memory_address  = AW'(a);
    bus.memory_data_in  = d;
    sync = s;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
    @(negedge clk);
    bus.memory_enable_n = 1'b1; bus.memory_write_n = 1'b1; bus.memory_read_n = 1'b1;
    sync = 1'b0;
  endtask

  task automatic wr_w(input int a, input logic [DW-1:0] d, input bit s = 1'b0);
    cycle(1'b1, 1'b1, 1'b0, a, d, s);
  endtask
  task automatic rd_w(input int a);
    cycle(1'b1, 1'b0, 1'b1, a, '0, 1'b0);
  endtask
  task automatic idle(input bit s = 1'b0);
    cycle(1'b0, 1'b0, 1'b0, 0, '0, s);
  endtask

  initial begin
    bus.memory_enable_n = 1'b1; bus.memory_write_n = 1'b1; bus.memory_read_n = 1'b1;
    bus.memory_address = '0; bus.memory_data_in = '0;
    model_reset();
    #2;
    check("reset_flat", 128'(ccr_flat), 128'(0));
    check("reset_pending", 128'(commit_pending), 128'(0));
    check("reset_rdata", 128'(bus.memory_data_out), 128'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    for (int a = 0; a < 10; a++) begin
      rd_w(a);
      check("read_after_reset", 128'(bus.memory_data_out), 128'(0));
    end

    // Staged write then commit on period_sync.
    wr_w(2, 16'h1234);
    wr_w(3, 16'hABCD);
    wr_w(1, 16'h8000);
    idle();
    check("flat_before_sync", 128'(ccr_flat[31:0]), SHADOW ? 128'(0) : 128'(32'hABCD1234));
    rd_w(1);
    check("ctrl_read", 128'(bus.memory_data_out), SHADOW ? 128'(16'h8000) : 128'(0));
    idle(1'b1);
    check("flat_after_sync", 128'(ccr_flat[31:0]), 128'(32'hABCD1234));
    check("pending_after_sync", 128'(commit_pending), 128'(0));

    // IMMEDIATE commit without period_sync.
    wr_w(1, 16'h0001);
    wr_w(4, 16'h0005);
    wr_w(1, 16'h8001);
    check("imm_pending", 128'(commit_pending), 128'(SHADOW));
    idle();
    check("imm_flat", 128'(ccr_flat[63:32]), 128'(32'h0000_0005));

    // Staging write coincident with the copy edge; repeated COMMIT does not queue.
    wr_w(1, 16'h0000);
    wr_w(1, 16'h8000);
    wr_w(1, 16'h8000);
    wr_w(2, 16'hFFFF, 1'b1);
    check("coincident_low", 128'(ccr_flat[15:0]), SHADOW ? 128'(16'h1234) : 128'(16'hFFFF));
    rd_w(2);
    check("staging_read", 128'(bus.memory_data_out), 128'(16'hFFFF));
    idle(1'b1);
    check("sync_no_pending", 128'(ccr_flat[15:0]), SHADOW ? 128'(16'h1234) : 128'(16'hFFFF));

    // COMMIT coinciding with period_sync: pending only, copy on the next sync.
    wr_w(1, 16'h8000, 1'b1);
    check("commit_sync_pend", 128'(commit_pending), 128'(SHADOW));
    check("commit_sync_nocopy", 128'(ccr_flat[15:0]), SHADOW ? 128'(16'h1234) : 128'(16'hFFFF));
    idle(1'b1);
    check("second_sync_copy", 128'(ccr_flat[15:0]), 128'(16'hFFFF));

    // Unmapped word is ignored and reads 0.
    wr_w(10, 16'h5555);
    rd_w(10);
    check("unmapped_read", 128'(bus.memory_data_out), 128'(0));
    wr_w(0, 16'hBEEF);
    rd_w(0);
    check("cell_read", 128'(bus.memory_data_out), 128'(16'hBEEF));

    // Reset asserted mid-cycle while a commit is pending.
    wr_w(1, 16'h8000);
    check("pend_before_rst", 128'(commit_pending), 128'(SHADOW));
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_pending", 128'(commit_pending), 128'(0));
    check("rst_flat", 128'(ccr_flat), 128'(0));
    check("rst_cell", 128'(cell_state), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    wr_w(0, 16'h1111);
    check("post_rst_write", 128'(cell_state), 128'(16'h1111));
    rd_w(1);
    check("post_rst_ctrl", 128'(bus.memory_data_out), 128'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ccr_register_file.md
CCR_REGISTER_FILE -- requirements
Module: ccr_register_file

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, meaning the number of compare channels (1..16).
REQ-002 SHALL have parameter DATA_WIDTH, default 16, meaning the bus word width; each CCR is 2*DATA_WIDTH bits.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, meaning the memory_address width (at least 6).
REQ-004 SHALL have port clock, input, 1, the single clock; all flops are rising-edge.
REQ-005 SHALL have port reset_sn, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports memory_enable_n, memory_write_n and memory_read_n, input, 1 each, active-low bus strobes.
REQ-007 SHALL have port memory_address, input, ADDR_WIDTH, word address.
REQ-008 SHALL have port memory_data_in, input, DATA_WIDTH, write data.
REQ-009 SHALL have port memory_data_out, output, DATA_WIDTH, registered read data.
REQ-010 SHALL have port period_sync, input, 1, one-cycle pulse marking the actuator period boundary.
REQ-011 SHALL have port cell_state, output, DATA_WIDTH, contents of word 0.
REQ-012 SHALL have port ccr_flat, output, NUM_CHANNELS*2*DATA_WIDTH; channel k occupies bits [k*2W +: 2W].
REQ-013 SHALL have port commit_pending, output, 1, high while a commit is waiting.

Function
REQ-014 SHALL use this map: word 0 cell_state; word 1 CTRL; word 2+2k CCRk low half; word 3+2k CCRk high half (staging).
REQ-015 SHALL treat any address >= 2+2*NUM_CHANNELS as unmapped: writes are ignored and reads return 0.
REQ-016 SHALL perform a write at the clock edge when memory_enable_n=0 and memory_write_n=0.
REQ-017 SHALL load memory_data_out one cycle after a cycle with memory_enable_n=0 and memory_read_n=0 (latency 1), and SHALL load 0 on all other cycles.
REQ-018 SHALL decode CTRL as: bit0 IMMEDIATE (read/write); bit15 COMMIT (write-1 sets commit_pending, self-clearing, never stored); all other bits read 0.
REQ-019 SHALL return CTRL reads as {commit_pending, 14'b0, IMMEDIATE}, zero-extended or truncated to DATA_WIDTH.
REQ-020 SHALL return the staging value, not the active value, on reads of CCR words.
REQ-021 SHALL copy all staging CCRs to the active CCRs (ccr_flat) and clear commit_pending at an edge where commit_pending=1 and either period_sync=1 or IMMEDIATE=1.
REQ-022 SHALL perform the copy using pre-edge staging values when a staging write coincides with the copy edge; the new write becomes visible only at the next commit.
REQ-023 SHALL set commit_pending without copying when the COMMIT write and period_sync coincide while commit_pending=0; the copy occurs on the following qualifying edge.
REQ-024 SHALL keep commit_pending=1 with no copy when COMMIT is rewritten while already pending, and SHALL NOT queue a second commit.
REQ-025 SHALL leave commit_pending unchanged and SHALL NOT copy on period_sync pulses while commit_pending=0.

Reset
REQ-026 SHALL clear cell_state, CTRL, all staging CCRs, ccr_flat, commit_pending and memory_data_out to 0 immediately on reset_sn=0, independent of clock.
REQ-027 SHALL discard any pending commit on reset asserted mid-operation, and SHALL accept bus cycles from the first rising edge after reset_sn deasserts.

Configuration
REQ-028 SHALL implement the staging/active double buffer (REQ-018 COMMIT, REQ-020 to REQ-025) when the macro CCR_SHADOW_EN is defined.
REQ-029 SHALL, when CCR_SHADOW_EN is undefined, write CCR words directly into ccr_flat at the write edge, tie commit_pending to 0, read CTRL bit15 as 0, and ignore period_sync.

Verification
REQ-030 SHALL verify: reset, then read words 0 to 9 -> all reads 0, each one cycle after its strobe; ccr_flat=0.
REQ-031 SHALL verify: write 0x1234 to word 2 and 0xABCD to word 3, then COMMIT, then period_sync -> ccr_flat[31:0] stays 0 until the sync edge, then equals 0xABCD1234, and commit_pending falls.
REQ-032 SHALL verify: IMMEDIATE=1, write word 4=0x0005, then COMMIT -> ccr_flat[63:32]=0x00000005 one edge after commit_pending rises, with no period_sync.
REQ-033 SHALL verify: commit pending, staging write of word 2=0xFFFF in the same cycle as period_sync -> active low half keeps the old value; a read of word 2 returns 0xFFFF.
REQ-034 SHALL verify: with NUM_CHANNELS=4, write 0x5555 to word 10, then read word 10 -> read returns 0 and all outputs are unchanged.
REQ-035 SHALL verify: assert reset_sn=0 mid-cycle while commit_pending=1 -> commit_pending and ccr_flat read 0 before the next edge; regression runs with CCR_SHADOW_EN both defined and undefined.
